err_demod_gen_v3: RTL and testbench
===================================

// Module: err_demod_gen_v3
// PURPOSE
//  Parametrised successor of the FOG square-wave error demodulator. Sits between the ADC
//  sync/FIR path and the FIR gate / feedback step gen in the DAC_CLK domain. Per modulation
//  half-period: wait for settling, average 2^k ADC samples, form err = +/-(H_avg - L_avg) - offset.
//  Emits sync pulses for the step and ramp generators. Counts aborted (overrun) half-periods.
// PARAMETERS
//  ADC_BIT       14  ADC sample width, signed two's complement
//  MAX_AVG_LOG2  8   max averaging exponent; i_avg_sel is clamped to this
//  STEP_DLY      2   cycles from o_step_sync to o_step_sync_dly (>=1)
// PORTS
//  i_clk            in   1        DAC_CLK domain clock
//  i_rst_n          in   1        synchronous, active-low reset
//  i_status         in   1        modulation half: 1=amp_H half, 0=amp_L half
//  i_trig           in   1        1-cycle pulse at every modulation half switch
//  i_polarity       in   32       bit0=1 negates the difference
//  i_wait_cnt       in   32       settling cycles after i_trig before sampling
//  i_err_offset     in   32s      subtracted from the difference
//  i_avg_sel        in   32       averaging exponent k, N=2^k samples
//  i_adc_data       in   ADC_BIT  synchronised ADC sample
//  o_step_sync      out  1        1-cycle pulse, o_err updated this cycle
//  o_step_sync_dly  out  1        o_step_sync delayed STEP_DLY cycles
//  o_rate_sync      out  1        o_step_sync_dly delayed 1 cycle
//  o_ramp_sync      out  1        i_trig registered, 1-cycle latency
//  o_err            out  32s      demodulated error
//  o_high_avg       out  32s      last H-half average, sign-extended
//  o_low_avg        out  32s      last L-half average, sign-extended
//  o_miss_cnt       out  16       saturating count of aborted half-periods
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, accumulators 0, h_valid=l_valid=0.
//  - FSM IDLE->WAIT on i_trig. Latch half=i_status, load wcnt=i_wait_cnt, acc=0, scnt=0.
//  - WAIT: wcnt==0 -> ACC next cycle, else wcnt--. i_wait_cnt=0 gives ACC on the cycle after i_trig.
//  - ACC: acc += sext(i_adc_data) each cycle. After N=2^k samples -> DONE.
//    k=min(i_avg_sel,MAX_AVG_LOG2). acc width ADC_BIT+MAX_AVG_LOG2, so no overflow.
//  - DONE (1 cycle): avg=acc>>>k (arithmetic). half=1 -> o_high_avg=avg, h_valid=1.
//    half=0 -> o_low_avg=avg, l_valid=1. Then -> IDLE.
//  - Err update in DONE when h_valid&l_valid:
//    d=H-L (ADC_BIT+1 bits); d=-d if polarity[0]; e=d-offset in 33 bits, saturated to 32 bits.
//    o_err<=e registered and o_step_sync=1 in the same cycle. No update before both halves are valid.
//  - i_trig in WAIT/ACC aborts the current half: no avg/err update, o_miss_cnt++ (saturates at
//    FFFF), immediate restart in WAIT with the new half. i_trig in DONE: DONE completes, then
//    WAIT starts next cycle (the trig is latched, never dropped).
//  - i_wait_cnt, i_avg_sel, i_polarity and i_err_offset are sampled on i_trig. Changes mid-half
//    affect the next half only. i_err_offset and i_polarity are applied at DONE.
//  - The sync pulses are exactly 1 cycle. Overlapping delay-line pulses are kept independently.
//  - Reset asserted mid-operation returns everything to reset values on the next edge.
// CONFIGURATION
//  ERR_CLAMP_EN defined:
//    adds port i_err_th (in 32, unsigned) and o_clamped (out 1).
//    o_err is limited to [-i_err_th, +i_err_th]; o_clamped=1 for the o_step_sync cycle when clamped.
//  ERR_CLAMP_EN undefined: the ports are absent, no clamping, o_err is the saturated e only.
// TESTING
//  1 reset: i_rst_n=0 3 cycles with random inputs -> all outputs 0, no sync pulses.
//  2 wait=4, avg_sel=2, H-half ADC=100, L-half ADC=-60, pol=0, off=0 -> after 2 halves
//    o_err=160, o_high_avg=100, o_low_avg=-60, o_step_sync_dly 2 cycles after o_step_sync,
//    o_rate_sync 1 cycle after that.
//  3 same as 2 with pol=1, off=10 -> o_err=-170. avg_sel=20 clamps to k=8 (256 samples per half).
//  4 i_trig reissued 3 cycles into ACC -> no o_step_sync for the aborted half, o_miss_cnt=1,
//    the following half measures normally.
//  5 ADC=8191 on H, -8192 on L, off=-(2^31-1) -> o_err=7FFFFFFF (saturated).
//  6 ERR_CLAMP_EN, i_err_th=50, case 2 stimulus -> o_err=50, o_clamped=1 for 1 cycle.

Source files
------------

// File: rtl/err_demod_gen_v3.sv
// Square-wave error demodulator: per half-period settle, average 2^k samples, form +/-(H-L)-offset.
// Optional output clamp enabled by defining ERR_CLAMP_EN (adds i_err_th / o_clamped).
module err_demod_gen_v3 #(
    parameter int ADC_BIT      = 14,
    parameter int MAX_AVG_LOG2 = 8,
    parameter int STEP_DLY     = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_status,
    input  logic                      i_trig,
    input  logic [31:0]               i_polarity,
    input  logic [31:0]               i_wait_cnt,
    input  logic signed [31:0]        i_err_offset,
    input  logic [31:0]               i_avg_sel,
    input  logic signed [ADC_BIT-1:0] i_adc_data,
`ifdef ERR_CLAMP_EN
    input  logic [31:0]               i_err_th,
    output logic                      o_clamped,
`endif
    output logic                      o_step_sync,
    output logic                      o_step_sync_dly,
    output logic                      o_rate_sync,
    output logic                      o_ramp_sync,
    output logic signed [31:0]        o_err,
    output logic signed [31:0]        o_high_avg,
    output logic signed [31:0]        o_low_avg,
    output logic [15:0]               o_miss_cnt
);
    localparam int AW = ADC_BIT + MAX_AVG_LOG2;
    localparam int KW = $clog2(MAX_AVG_LOG2 + 1);
    localparam int SW = MAX_AVG_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_DONE} state_t;
    state_t state, state_d;

    logic                      half, pol_q, h_valid, l_valid;
    logic [31:0]               wcnt;
    logic [KW-1:0]             k_q, k_in;
    logic signed [31:0]        off_q;
    logic signed [AW-1:0]      acc, acc_sh;
    logic [SW-1:0]             scnt, n_m1;
    logic [STEP_DLY-1:0]       dly_pipe;
    logic                      load, miss_inc, clamp_hit;
    logic signed [ADC_BIT-1:0] avg, h_new, l_new;
    logic signed [ADC_BIT:0]   d;
    logic signed [32:0]        d33, dp, e33;
    logic signed [31:0]        e32, e_out;

    assign k_in   = (i_avg_sel > MAX_AVG_LOG2) ? KW'(MAX_AVG_LOG2) : i_avg_sel[KW-1:0];
    assign n_m1   = (SW'(1) << k_q) - SW'(1);
    assign acc_sh = acc >>> k_q;
    assign avg    = acc_sh[ADC_BIT-1:0];

    // The freshly averaged half replaces its stored counterpart before the difference is formed.
    assign h_new = half ? avg : o_high_avg[ADC_BIT-1:0];
    assign l_new = half ? o_low_avg[ADC_BIT-1:0] : avg;
    assign d     = {h_new[ADC_BIT-1], h_new} - {l_new[ADC_BIT-1], l_new};
    assign d33   = {{(32-ADC_BIT){d[ADC_BIT]}}, d};
    assign dp    = pol_q ? -d33 : d33;
    assign e33   = dp - {off_q[31], off_q};
    assign e32   = (e33[32] != e33[31]) ? (e33[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : e33[31:0];

`ifdef ERR_CLAMP_EN
    logic signed [33:0] th34, e34, neg_th;
    always_comb begin
        th34      = {2'b00, i_err_th};
        e34       = {{2{e32[31]}}, e32};
        neg_th    = -th34;
        e_out     = e32;
        clamp_hit = 1'b0;
        if (e34 > th34) begin
            e_out     = th34[31:0];
            clamp_hit = 1'b1;
        end else if (e34 < neg_th) begin
            e_out     = neg_th[31:0];
            clamp_hit = 1'b1;
        end
    end
`else
    assign e_out     = e32;
    assign clamp_hit = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, i_polarity[31:1], acc_sh[AW-1:ADC_BIT], clamp_hit};

    // A trig in WAIT/ACC aborts the half; a trig in DONE lets DONE finish and restarts right after.
    always_comb begin
        state_d  = state;
        load     = 1'b0;
        miss_inc = 1'b0;
        case (state)
            S_IDLE: load = i_trig;
            S_WAIT: begin
                if (i_trig) begin
                    load     = 1'b1;
                    miss_inc = 1'b1;
                end else if (wcnt == '0) state_d = S_ACC;
            end
            S_ACC: begin
                if (i_trig) begin
                    load     = 1'b1;
                    miss_inc = 1'b1;
                end else if (scnt == n_m1) state_d = S_DONE;
            end
            S_DONE: begin
                if (i_trig) load = 1'b1;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (load) state_d = (i_wait_cnt == '0) ? S_ACC : S_WAIT;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            half        <= 1'b0;
            pol_q       <= 1'b0;
            h_valid     <= 1'b0;
            l_valid     <= 1'b0;
            wcnt        <= '0;
            k_q         <= '0;
            off_q       <= '0;
            acc         <= '0;
            scnt        <= '0;
            dly_pipe    <= '0;
            o_step_sync <= 1'b0;
            o_rate_sync <= 1'b0;
            o_ramp_sync <= 1'b0;
            o_err       <= '0;
            o_high_avg  <= '0;
            o_low_avg   <= '0;
            o_miss_cnt  <= '0;
`ifdef ERR_CLAMP_EN
            o_clamped   <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            o_ramp_sync <= i_trig;
            o_step_sync <= 1'b0;
            dly_pipe[0] <= o_step_sync;
            for (int i = 1; i < STEP_DLY; i++) dly_pipe[i] <= dly_pipe[i-1];
            o_rate_sync <= dly_pipe[STEP_DLY-1];
`ifdef ERR_CLAMP_EN
            o_clamped   <= 1'b0;
`endif
            if (miss_inc && o_miss_cnt != 16'hFFFF) o_miss_cnt <= o_miss_cnt + 16'd1;

            if (load) begin
                half  <= i_status;
                wcnt  <= i_wait_cnt - 32'd1;
                k_q   <= k_in;
                pol_q <= i_polarity[0];
                off_q <= i_err_offset;
                acc   <= '0;
                scnt  <= '0;
            end else if (state == S_WAIT) begin
                if (wcnt != '0) wcnt <= wcnt - 32'd1;
            end else if (state == S_ACC) begin
                acc  <= acc + {{MAX_AVG_LOG2{i_adc_data[ADC_BIT-1]}}, i_adc_data};
                scnt <= scnt + SW'(1);
            end

            if (state == S_DONE) begin
                if (half) begin
                    o_high_avg <= {{(32-ADC_BIT){avg[ADC_BIT-1]}}, avg};
                    h_valid    <= 1'b1;
                end else begin
                    o_low_avg  <= {{(32-ADC_BIT){avg[ADC_BIT-1]}}, avg};
                    l_valid    <= 1'b1;
                end
                if ((half || h_valid) && (!half || l_valid)) begin
                    o_err       <= e_out;
                    o_step_sync <= 1'b1;
`ifdef ERR_CLAMP_EN
                    o_clamped   <= clamp_hit;
`endif
                end
            end
        end
    end

    assign o_step_sync_dly = dly_pipe[STEP_DLY-1];
endmodule

// File: tb/tb_err_demod_gen_v3.sv
// Scoreboard bench for err_demod_gen_v3: each completed measurement pushes its expected result.
module tb_err_demod_gen_v3;
    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_status = 1'b0, i_trig = 1'b0;
    logic [31:0]        i_polarity = '0, i_wait_cnt = '0, i_avg_sel = '0;
    logic signed [31:0] i_err_offset = '0;
    logic signed [13:0] i_adc_data = '0;
    logic               o_step_sync, o_step_sync_dly, o_rate_sync, o_ramp_sync;
    logic signed [31:0] o_err, o_high_avg, o_low_avg;
    logic [15:0]        o_miss_cnt;
`ifdef ERR_CLAMP_EN
    logic [31:0]        i_err_th = 32'hFFFF_FFFF;
    logic               o_clamped;
`endif

    err_demod_gen_v3 #(.ADC_BIT(14), .MAX_AVG_LOG2(8), .STEP_DLY(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_status(i_status), .i_trig(i_trig),
        .i_polarity(i_polarity), .i_wait_cnt(i_wait_cnt), .i_err_offset(i_err_offset),
        .i_avg_sel(i_avg_sel), .i_adc_data(i_adc_data),
`ifdef ERR_CLAMP_EN
        .i_err_th(i_err_th), .o_clamped(o_clamped),
`endif
        .o_step_sync(o_step_sync), .o_step_sync_dly(o_step_sync_dly), .o_rate_sync(o_rate_sync),
        .o_ramp_sync(o_ramp_sync), .o_err(o_err), .o_high_avg(o_high_avg), .o_low_avg(o_low_avg),
        .o_miss_cnt(o_miss_cnt));

    always #5 i_clk = ~i_clk;

    typedef struct {longint err; longint h; longint l; longint lat; bit clamped;} exp_t;
    exp_t   sb[$];
    int     n_chk = 0, n_err = 0;
    longint cyc = 0, trig_cyc = 0;
    longint m_h = 0, m_l = 0, m_th = 64'hFFFF_FFFF;
    bit     m_hv = 0, m_lv = 0;
    logic [2:0] sh = '0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        exp_t e;
        if (o_step_sync === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_step", 1, 0);
            else begin
                e = sb.pop_front();
                chk("err", longint'(o_err), e.err);
                chk("high_avg", longint'(o_high_avg), e.h);
                chk("low_avg", longint'(o_low_avg), e.l);
                chk("latency", cyc - trig_cyc, e.lat);
`ifdef ERR_CLAMP_EN
                chk("clamped", longint'(o_clamped), longint'(e.clamped));
`endif
            end
        end
`ifdef ERR_CLAMP_EN
        if (o_step_sync !== 1'b1 && o_clamped === 1'b1) chk("clamped_len", 1, 0);
`endif
        if (sh[1] === 1'b1 || o_step_sync_dly === 1'b1) chk("step_dly", longint'(o_step_sync_dly), longint'(sh[1]));
        if (sh[2] === 1'b1 || o_rate_sync === 1'b1) chk("rate_sync", longint'(o_rate_sync), longint'(sh[2]));
        sh = {sh[1:0], o_step_sync};
    end

    // Reset with random inputs; every output must read zero while held.
    task automatic do_reset();
        i_rst_n = 1'b0;
        m_hv = 0; m_lv = 0; m_h = 0; m_l = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_trig = 1'($urandom); i_status = 1'($urandom); i_adc_data = 14'($urandom);
            i_wait_cnt = $urandom_range(0, 7); i_avg_sel = $urandom; i_polarity = $urandom;
            i_err_offset = $urandom;
            @(posedge i_clk); #1;
            chk("rst_outs", longint'({o_step_sync, o_step_sync_dly, o_rate_sync, o_ramp_sync}), 0);
            chk("rst_err", longint'(o_err), 0);
            chk("rst_avgs", longint'(o_high_avg | o_low_avg), 0);
            chk("rst_miss", longint'(o_miss_cnt), 0);
        end
        @(negedge i_clk);
        i_trig = 1'b0;
        i_rst_n = 1'b1;
    endtask

    // One modulation half at constant ADC level; abort_after>=0 leaves it running for the next trig.
    task automatic run_half(input bit st, input int w, input int k, input bit pol, input longint off,
                            input int adc, input int abort_after);
        int kc, n;
        longint d, e;
        exp_t x;
        kc = (k > 8) ? 8 : k;
        n  = 1 << kc;
        @(negedge i_clk);
        i_trig = 1'b1; i_status = st; i_wait_cnt = w; i_avg_sel = k;
        i_polarity = {31'b0, pol}; i_err_offset = off[31:0]; i_adc_data = adc[13:0];
        trig_cyc = cyc;
        if (abort_after < 0) begin
            if (st) begin m_h = adc; m_hv = 1; end
            else    begin m_l = adc; m_lv = 1; end
            if (m_hv && m_lv) begin
                d = m_h - m_l;
                if (pol) d = -d;
                e = d - off;
                if (e > 64'sd2147483647) e = 64'sd2147483647;
                if (e < -64'sd2147483648) e = -64'sd2147483648;
                x.clamped = 0;
`ifdef ERR_CLAMP_EN
                if (e > m_th) begin e = m_th; x.clamped = 1; end
                else if (e < -m_th) begin e = -m_th; x.clamped = 1; end
`endif
                x.err = e; x.h = m_h; x.l = m_l; x.lat = w + n + 2;
                sb.push_back(x);
            end
        end
        @(negedge i_clk);
        i_trig = 1'b0;
        if (abort_after >= 0) repeat (abort_after - 1) @(negedge i_clk);
        else repeat (w + n + 6) @(negedge i_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        // basic H/L difference
        run_half(1, 4, 2, 0, 0, 100, -1);
        run_half(0, 4, 2, 0, 0, -60, -1);
        chk("miss_none", longint'(o_miss_cnt), 0);
        // inverted polarity with offset, averaging exponent clamped to 8
        run_half(1, 4, 20, 1, 10, 100, -1);
        run_half(0, 4, 20, 1, 10, -60, -1);
        // zero settling time
        run_half(1, 0, 1, 0, 5, 37, -1);
        // positive and negative saturation
        run_half(1, 3, 2, 0, -64'sd2147483647, 8191, -1);
        run_half(0, 3, 2, 0, -64'sd2147483647, -8192, -1);
        run_half(0, 3, 2, 1, 64'sd2147483647, -8192, -1);
        chk("sb_empty_a", sb.size(), 0);

        // abort in ACC: aborted half must not touch averages or produce a step
        do_reset();
        run_half(1, 4, 2, 0, 0, 100, -1);
        run_half(0, 4, 3, 0, 0, 555, 7);
        run_half(1, 4, 3, 0, 0, 999, 7);
        run_half(0, 4, 2, 0, 0, -60, -1);
        chk("miss_one", longint'(o_miss_cnt), 2);
        chk("sb_empty_b", sb.size(), 0);

`ifdef ERR_CLAMP_EN
        do_reset();
        i_err_th = 32'd50; m_th = 50;
        run_half(1, 4, 2, 0, 0, 100, -1);
        run_half(0, 4, 2, 0, 0, -60, -1);
        run_half(1, 4, 2, 1, 0, 100, -1);
        chk("sb_empty_c", sb.size(), 0);
`endif
        repeat (4) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
